// File: rtl/sobel_window_gen.sv
// 3x3 window generator for the sobel kernel: two line buffers plus a shift window.
// Emits one registered window per interior pixel of a raster-order frame.
module sobel_window_gen #(
    parameter int IMG_W = 352,
    parameter int IMG_H = 288
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_sof,
    input  logic [7:0] in_pixel,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_eof,
    output logic [7:0] s11,
    output logic [7:0] s12,
    output logic [7:0] s13,
    output logic [7:0] s21,
    output logic [7:0] s22,
    output logic [7:0] s23,
    output logic [7:0] s31,
    output logic [7:0] s32,
    output logic [7:0] s33
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef enum logic {FILL, RUN} state_t;

    state_t        state_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic [7:0]    lb0 [IMG_W];
    logic [7:0]    lb1 [IMG_W];
    logic [7:0]    sh_q [3][2];
    logic [7:0]    win_q [3][3];
    logic          out_valid_q;
    logic          out_eof_q;

    logic          accept;
    logic          load;
    logic [CW-1:0] col_c;
    logic [RW-1:0] row_c;
    logic          col_last;
    logic          row_last;
    logic [7:0]    nxt [3];

    assign in_ready = !out_valid_q || out_ready;

    // in_sof retargets the accepted pixel to (0,0) before any decision is made
    always_comb begin
        accept   = in_valid && in_ready;
        col_c    = in_sof ? '0 : col_q;
        row_c    = in_sof ? '0 : row_q;
        col_last = (col_c == CW'(IMG_W - 1));
        row_last = (row_c == RW'(IMG_H - 1));
        load     = accept && !in_sof && (state_q == RUN) && (col_q >= CW'(2));
        nxt[0]   = lb1[col_c];
        nxt[1]   = lb0[col_c];
        nxt[2]   = in_pixel;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col_c] <= lb0[col_c];
            lb0[col_c] <= in_pixel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_eof_q   <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                sh_q[r][0] <= '0;
                sh_q[r][1] <= '0;
                for (int c = 0; c < 3; c++) win_q[r][c] <= '0;
            end
        end else begin
            if (accept) begin
                col_q <= col_last ? '0 : col_c + CW'(1);
                if (col_last) row_q <= row_last ? '0 : row_c + RW'(1);
                else          row_q <= row_c;

                if (in_sof || (row_last && col_last))
                    state_q <= FILL;
                else if (row_c == RW'(2) && col_c == '0)
                    state_q <= RUN;

                for (int r = 0; r < 3; r++) begin
                    sh_q[r][0] <= sh_q[r][1];
                    sh_q[r][1] <= nxt[r];
                end
            end

            // a fresh load overrides the handshake clear, so no bubble
            if (load) begin
                out_valid_q <= 1'b1;
                out_eof_q   <= row_last && col_last;
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= sh_q[r][0];
                    win_q[r][1] <= sh_q[r][1];
                    win_q[r][2] <= nxt[r];
                end
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
                out_eof_q   <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_eof   = out_eof_q;
    assign s11 = win_q[0][0];
    assign s12 = win_q[0][1];
    assign s13 = win_q[0][2];
    assign s21 = win_q[1][0];
    assign s22 = win_q[1][1];
    assign s23 = win_q[1][2];
    assign s31 = win_q[2][0];
    assign s32 = win_q[2][1];
    assign s33 = win_q[2][2];
endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on a 5x4 frame.
// Windows are collected by a monitor and compared against ramp-derived values.
module tb_sobel_window_gen;
    localparam int W = 5;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_sof = 1'b0;
    logic [7:0] in_pixel = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_eof;
    logic [7:0] s11, s12, s13, s21, s22, s23, s31, s32, s33;

    typedef struct packed {
        logic [71:0] w;
        logic        e;
    } rec_t;

    rec_t got_q[$];
    rec_t exp_q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    sobel_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sof(in_sof), .in_pixel(in_pixel),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_eof(out_eof),
        .s11(s11), .s12(s12), .s13(s13),
        .s21(s21), .s22(s22), .s23(s23),
        .s31(s31), .s32(s32), .s33(s33)
    );

    always #5 clk = ~clk;

    function automatic logic [71:0] win_now();
        return {s11, s12, s13, s21, s22, s23, s31, s32, s33};
    endfunction

    // window produced by pixel (r,c) of a ramp frame: value = base + 10*row + col
    function automatic logic [71:0] exp_win(input int base, input int r, input int c);
        logic [71:0] v;
        v = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                v[71 - 8*(3*i+j) -: 8] = 8'(base + 10*(r-2+i) + (c-2+j));
        return v;
    endfunction

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    always @(negedge clk)
        if (rst_n && out_valid && out_ready)
            got_q.push_back('{w: win_now(), e: out_eof});

    task automatic send_px(input logic [7:0] p, input bit sof, input int gap);
        bit rdy;
        int n;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_pixel = p;
        in_sof   = sof;
        rdy = 1'b0;
        n = 0;
        while (!rdy && n < 100) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!rdy) chk("send_timeout", 72'd0, 72'd1);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_frame(input int base, input bit sof, input bit rnd,
                              input int k0, input int k1);
        for (int k = k0; k <= k1; k++)
            send_px(8'(base + 10*(k/W) + k%W), sof && k == 0,
                    rnd ? int'($urandom_range(0, 1)) : 0);
    endtask

    task automatic add_exp(input int base);
        for (int r = 2; r < H; r++)
            for (int c = 2; c < W; c++)
                exp_q.push_back('{w: exp_win(base, r, c), e: (r == H-1 && c == W-1)});
    endtask

    task automatic compare(input string name);
        repeat (5) @(posedge clk);
        #1;
        chk($sformatf("%s_count", name), 72'(got_q.size()), 72'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("%s_win%0d", name, i), got_q[i].w, exp_q[i].w);
            chk($sformatf("%s_eof%0d", name, i), 72'(got_q[i].e), 72'(exp_q[i].e));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic stall3();
        logic [71:0] held;
        int n;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!out_valid) begin
            chk("stall_wait", 72'd0, 72'd1);
        end else begin
            out_ready = 1'b0;
            held = win_now();
            repeat (3) @(posedge clk);
            #1;
            chk("stall_in_ready", 72'(in_ready), 72'd0);
            chk("stall_valid", 72'(out_valid), 72'd1);
            chk("stall_held", win_now(), held);
            out_ready = 1'b1;
        end
    endtask

    initial begin
        #1;
        chk("rst_valid", 72'(out_valid), 72'd0);
        chk("rst_in_ready", 72'(in_ready), 72'd1);
        chk("rst_win", win_now(), 72'd0);
        #11 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // reset mid-stream
        send_frame(0, 1, 0, 0, 13);
        chk("pre_rst_valid", 72'(out_valid), 72'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", 72'(out_valid), 72'd0);
        chk("async_win", win_now(), 72'd0);
        chk("async_eof", 72'(out_eof), 72'd0);
        #2 rst_n = 1'b1;
        got_q.delete();
        @(posedge clk);
        #1;

        // ramp frame at full throughput, no sof: counters must restart at (0,0)
        send_frame(0, 0, 0, 0, 11);
        chk("fill_no_valid", 72'(out_valid), 72'd0);
        send_frame(0, 0, 0, 12, 12);
        chk("lat_valid", 72'(out_valid), 72'd1);
        chk("first_win", win_now(), exp_win(0, 2, 2));
        send_frame(0, 0, 0, 13, 19);
        add_exp(0);
        compare("ramp");

        // downstream back-pressure
        fork
            begin
                send_frame(0, 1, 0, 0, W*H-1);
            end
            stall3();
        join
        add_exp(0);
        compare("stall");

        // random input gaps
        send_frame(0, 1, 1, 0, W*H-1);
        add_exp(0);
        compare("gaps");

        // sof at (2,3) restarts the frame
        send_frame(0, 1, 0, 0, 12);
        send_frame(50, 1, 0, 0, 11);
        chk("sof_no_win", 72'(got_q.size()), 72'd1);
        send_frame(50, 0, 0, 12, 19);
        exp_q.push_back('{w: exp_win(0, 2, 2), e: 1'b0});
        add_exp(50);
        compare("sof");

        // two back-to-back frames
        send_frame(100, 1, 0, 0, W*H-1);
        send_frame(150, 1, 0, 0, W*H-1);
        add_exp(100);
        add_exp(150);
        compare("b2b");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
